// File: rtl/times_table_axil_reader_pkg.sv
// Shared types and constants for the times-table AXI4-Lite read initiator.
// Holds the FSM state encoding, table geometry and the product/offset helpers.
package times_table_axil_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam int         TABLE_ENTRIES = 64;
  localparam int         A_W           = 3;
  localparam int         R_W           = 6;

  // 3x3 unsigned product; max 7*7=49 always fits in 6 bits.
  function automatic logic [R_W-1:0] product(input logic [A_W-1:0] x, input logic [A_W-1:0] y);
    return R_W'(x) * R_W'(y);
  endfunction

  // Byte offset of entry {x,y} inside the word-addressed table.
  function automatic logic [31:0] entry_offset(input logic [A_W-1:0] x, input logic [A_W-1:0] y);
    logic [$clog2(TABLE_ENTRIES)-1:0] idx;
    idx = {x, y};
    return {24'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/times_table_axil_reader_if.sv
// AXI4-Lite read-channel bundle (AR + R) between the reader and its responder.
interface times_table_axil_reader_if;

  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/times_table_axil_reader.sv
// AXI4-Lite read initiator: turns a level "enable" with operands a,b into a single
// outstanding read of the product table and returns the 6-bit product as result.
module times_table_axil_reader
  import times_table_axil_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 16,
  parameter bit          CHECK_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [A_W-1:0]      a,
  input  logic [A_W-1:0]      b,
  input  logic                enable,
  output logic [R_W-1:0]      result,
  output logic                result_valid,
  output logic                busy,
  output logic                err,
  times_table_axil_reader_if.master m
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t           state_reg;
  logic [A_W-1:0]   a_reg;
  logic [A_W-1:0]   b_reg;
  logic [TMR_W-1:0] timer_reg;
  logic             timer_sat;
  logic             timer_hit;
  logic [R_W-1:0]   rdata_low;
  logic             unused_rdata;

  assign m.arprot     = 3'b000;
  assign timer_sat    = (timer_reg == TMR_W'(TIMEOUT));
  assign timer_hit    = (timer_reg == TMR_W'(TIMEOUT - 1));
  assign rdata_low    = m.rdata[R_W-1:0];
  assign unused_rdata = ^m.rdata[31:R_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      timer_reg    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      m.araddr     <= BASE_ADDR;
      m.arvalid    <= 1'b0;
      m.rready     <= 1'b0;
    end else begin
      result_valid <= 1'b0;

      // Wait-time watchdog: flags err once but never aborts the transfer.
      // State entries below reset the counter by overriding this update.
      if (state_reg != S_IDLE) begin
        if (!timer_sat) timer_reg <= timer_reg + 1'b1;
        if (timer_hit)  err       <= 1'b1;
      end

      unique case (state_reg)
        S_IDLE: begin
          if (enable) begin
            a_reg     <= a;
            b_reg     <= b;
            m.araddr  <= BASE_ADDR + entry_offset(a, b);
            m.arvalid <= 1'b1;
            busy      <= 1'b1;
            timer_reg <= '0;
            state_reg <= S_AR;
          end
        end

        S_AR: begin
          if (m.arready) begin
            m.arvalid <= 1'b0;
            m.rready  <= 1'b1;
            timer_reg <= '0;
            state_reg <= S_R;
          end
        end

        S_R: begin
          if (m.rvalid) begin
            result       <= rdata_low;
            result_valid <= 1'b1;
            m.rready     <= 1'b0;
            busy         <= 1'b0;
            state_reg    <= S_IDLE;
            if (m.rresp != RESP_OKAY) err <= 1'b1;
            if (CHECK_EN && (rdata_low != product(a_reg, b_reg))) err <= 1'b1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
